// File: rtl/ui_digit_blinker_pkg.sv
// Shared encodings for the digit blinker: display modes and blink phase.
package ui_pkg;

   localparam logic [1:0] UI_MODE_PASS = 2'd0;
   localparam logic [1:0] UI_MODE_SEL  = 2'd1;
   localparam logic [1:0] UI_MODE_ALL  = 2'd2;
   localparam logic [1:0] UI_MODE_INV  = 2'd3;

   typedef enum logic {
      PH_ON  = 1'b0,
      PH_OFF = 1'b1
   } phase_e;

endpackage

// File: rtl/ui_digit_blinker_if.sv
// Bundle of control inputs and masked outputs between the digit-line encoder
// (master) and the blinker (slave).
interface ui_digit_blinker_if #(
   parameter int N_DIGITS = 32,
   parameter int SEL_W    = 5,
   parameter int CNT_W    = 8
) ();

   logic                tick;
   logic                prog_running;
   logic [1:0]          mode;
   logic [SEL_W-1:0]    digit;
   logic [CNT_W-1:0]    on_time;
   logic [CNT_W-1:0]    off_time;
   logic [N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0] digits_out;
   logic                blink_on;

   modport master (
      output tick, prog_running, mode, digit, on_time, off_time, digits,
      input  digits_out, blink_on
   );

   modport slave (
      input  tick, prog_running, mode, digit, on_time, off_time, digits,
      output digits_out, blink_on
   );

endinterface

// File: rtl/ui_digit_blinker_timer.sv
// ON/OFF blink phase timer. Advances only on tick; restarts at ON with a
// fresh count when the cursor moves or while the program is running.
//
//   state  | meaning
//   PH_ON  | selected digits visible, counting on_time ticks
//   PH_OFF | selected digits blanked, counting off_time ticks
module ui_blink_timer
   import ui_pkg::*;
#(
   parameter int SEL_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick_i,
   input  logic             prog_running_i,
   input  logic [SEL_W-1:0] digit_i,
   input  logic [CNT_W-1:0] on_time_i,
   input  logic [CNT_W-1:0] off_time_i,
   output phase_e           phase_o,
   output phase_e           phase_next_o
);

   phase_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] digit_q;
   logic [CNT_W-1:0] dur;
   logic [CNT_W:0]   cnt_inc;

   // State, counter and cursor history registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= PH_ON;
         cnt_q   <= '0;
         digit_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         digit_q <= digit_i;
      end
   end

   // Next phase: restart/force has priority over tick-driven transitions.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dur     = (state_q == PH_ON) ? on_time_i : off_time_i;
      if (dur == '0) begin
         dur = {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // Extra bit so an all-ones count still compares correctly.
      cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
      if (prog_running_i || (digit_i != digit_q)) begin
         state_d = PH_ON;
         cnt_d   = '0;
      end else if (tick_i) begin
         if (cnt_inc >= {1'b0, dur}) begin
            state_d = (state_q == PH_ON) ? PH_OFF : PH_ON;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
         end
      end
   end

   assign phase_o      = state_q;
   assign phase_next_o = state_d;

endmodule

// File: rtl/ui_digit_blinker.sv
// Digit blinker top: blink timer, per-digit mask generator and registered
// masked digit lines. blink_on is the timer's phase register itself.
module ui_digit_blinker
   import ui_pkg::*;
#(
   parameter int N_DIGITS = 32,
   parameter int SEL_W    = 5,
   parameter int CNT_W    = 8
) (
   input logic                  clock,
   input logic                  reset,
   ui_digit_blinker_if.slave    bus
);

   phase_e              phase, phase_next;
   logic                blink_on_n;
   logic [N_DIGITS-1:0] sel;
   logic [N_DIGITS-1:0] show;
   logic [N_DIGITS-1:0] digits_out_q;

   ui_blink_timer #(
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
   ) u_timer (
      .clock          (clock),
      .reset          (reset),
      .tick_i         (bus.tick),
      .prog_running_i (bus.prog_running),
      .digit_i        (bus.digit),
      .on_time_i      (bus.on_time),
      .off_time_i     (bus.off_time),
      .phase_o        (phase),
      .phase_next_o   (phase_next)
   );

   assign blink_on_n = (phase_next == PH_ON);

   // Per-line visibility; an out-of-range cursor matches no line.
   always_comb begin
      sel  = '0;
      show = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         sel[i] = (32'(bus.digit) == 32'(i));
      end
      if (!bus.prog_running) begin
         case (bus.mode)
            UI_MODE_SEL: show = ~sel | {N_DIGITS{blink_on_n}};
            UI_MODE_ALL: show = {N_DIGITS{blink_on_n}};
            UI_MODE_INV: show = sel | {N_DIGITS{blink_on_n}};
            default:     show = '1;
         endcase
      end
   end

   // Registered masked digit lines.
   always_ff @(posedge clock) begin
      if (reset) begin
         digits_out_q <= '0;
      end else begin
         digits_out_q <= bus.digits & show;
      end
   end

   assign bus.digits_out = digits_out_q;
   assign bus.blink_on   = (phase == PH_ON);

endmodule

// File: tb/tb_ui_digit_blinker.sv
// Directed test for ui_digit_blinker. Stimulus is applied on the falling edge
// and the hand-computed register contents after the next rising edge are
// queued; a monitor pops and compares one entry per rising edge.
// Instance A uses 32 lines; instance B uses 10 lines with an out-of-range
// cursor (12) in select mode, so its lines must never be blanked.
module tb_ui_digit_blinker;

   typedef struct packed {
      logic [31:0] out_a;
      logic        blink_a;
      logic [9:0]  out_b;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t e;

   ui_digit_blinker_if #(.N_DIGITS(32), .SEL_W(5), .CNT_W(8)) ifa ();
   ui_digit_blinker_if #(.N_DIGITS(10), .SEL_W(4), .CNT_W(8)) ifb ();

   ui_digit_blinker #(.N_DIGITS(32), .SEL_W(5), .CNT_W(8)) dut_a (
      .clock (clk),
      .reset (rst),
      .bus   (ifa)
   );

   ui_digit_blinker #(.N_DIGITS(10), .SEL_W(4), .CNT_W(8)) dut_b (
      .clock (clk),
      .reset (rst),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   // Monitor: one output word per rising edge once stimulus is queued.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (ifa.digits_out !== e.out_a) begin
            errors++;
            $display("FAIL digits_out_a: got %h want %h at %0t", ifa.digits_out, e.out_a, $time);
         end
         checks++;
         if (ifa.blink_on !== e.blink_a) begin
            errors++;
            $display("FAIL blink_on_a: got %b want %b at %0t", ifa.blink_on, e.blink_a, $time);
         end
         checks++;
         if (ifb.digits_out !== e.out_b) begin
            errors++;
            $display("FAIL digits_out_b: got %h want %h at %0t", ifb.digits_out, e.out_b, $time);
         end
      end
   end

   task automatic drive(input logic r, input logic t, input logic p, input logic [1:0] m,
                        input logic [4:0] d, input logic [7:0] on, input logic [7:0] off,
                        input logic [31:0] dg);
      rst               = r;
      ifa.tick          = t;
      ifa.prog_running  = p;
      ifa.mode          = m;
      ifa.digit         = d;
      ifa.on_time       = on;
      ifa.off_time      = off;
      ifa.digits        = dg;
   endtask

   // Queue the expected result of the inputs now applied, then advance.
   task automatic step(input logic [31:0] ea, input logic eb);
      exp_t x;
      x.out_a   = ea;
      x.blink_a = eb;
      x.out_b   = rst ? 10'h000 : 10'h3FF;
      sb.push_back(x);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ifb.tick         = 1'b1;
      ifb.prog_running = 1'b0;
      ifb.mode         = 2'd1;
      ifb.digit        = 4'd12;
      ifb.on_time      = 8'd1;
      ifb.off_time     = 8'd1;
      ifb.digits       = 10'h3FF;
      drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 8'd0, 8'd0, 32'h0);
      @(negedge clk);

      // reset state
      step(32'h0, 1'b1);
      step(32'h0, 1'b1);

      // mode 1, cursor 3, on=2 off=3; first cycle restarts on cursor move
      drive(1'b0, 1'b1, 1'b0, 2'd1, 5'd3, 8'd2, 8'd3, 32'hFFFFFFFF);
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFF7, 1'b0);
      step(32'hFFFFFFF7, 1'b0);
      step(32'hFFFFFFF7, 1'b0);
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFF7, 1'b0);
      step(32'hFFFFFFF7, 1'b0);

      // cursor move during OFF restarts ON immediately
      ifa.digit = 5'd7;
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFF7F, 1'b0);

      // program running forces ON and shows everything
      ifa.prog_running = 1'b1;
      ifa.mode         = 2'd2;
      ifa.digits       = 32'h12345678;
      step(32'h12345678, 1'b1);
      ifa.digit = 5'd0;
      step(32'h12345678, 1'b1);
      ifa.prog_running = 1'b0;
      step(32'h12345678, 1'b1);
      step(32'h00000000, 1'b0);

      // mode 3 in OFF shows only the selected line; mode 0 shows all
      ifa.mode   = 2'd3;
      ifa.digits = 32'hA5A5A5A5;
      step(32'h00000001, 1'b0);
      ifa.mode = 2'd0;
      step(32'hA5A5A5A5, 1'b0);
      step(32'hA5A5A5A5, 1'b1);

      // zero durations behave as one tick
      ifa.on_time  = 8'd0;
      ifa.off_time = 8'd0;
      ifa.mode     = 2'd2;
      ifa.digits   = 32'hFFFFFFFF;
      step(32'h00000000, 1'b0);
      step(32'hFFFFFFFF, 1'b1);
      step(32'h00000000, 1'b0);
      step(32'hFFFFFFFF, 1'b1);
      step(32'h00000000, 1'b0);

      // no tick: frozen in OFF
      ifa.tick = 1'b0;
      for (int i = 0; i < 10; i++) step(32'h00000000, 1'b0);
      ifa.tick = 1'b1;
      step(32'hFFFFFFFF, 1'b1);

      // shrinking on_time below the current count transitions on next tick
      ifa.on_time  = 8'd5;
      ifa.off_time = 8'd1;
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFFF, 1'b1);
      step(32'hFFFFFFFF, 1'b1);
      ifa.on_time = 8'd2;
      step(32'h00000000, 1'b0);

      // reset mid-count in OFF
      ifa.off_time = 8'd3;
      step(32'h00000000, 1'b0);
      rst = 1'b1;
      step(32'h00000000, 1'b1);
      rst = 1'b0;
      step(32'hFFFFFFFF, 1'b1);
      step(32'h00000000, 1'b0);
      step(32'h00000000, 1'b0);
      step(32'h00000000, 1'b0);
      step(32'hFFFFFFFF, 1'b1);

      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ui_digit_blinker.md
Name: ui_digit_blinker

Overview:
Parametrised successor to the UI digit-flash stage. It owns its own blink timer: a tick-driven ON/OFF phase state machine with programmable on/off durations. The phase restarts when the cursor moves. Four display modes are supported, and the output is registered. It sits between the digit-line encoder and the display driver.

Parameters:
N_DIGITS, 32, number of digit lines (1..64)
SEL_W, 5, width of digit select; must satisfy 2**SEL_W >= N_DIGITS
CNT_W, 8, width of the phase counter and of the on/off duration inputs

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  single-cycle timebase strobe; phase counter advances only on tick
prog_running  in  1  program executing; suppresses all blinking
mode  in  2  0=pass-through, 1=blink selected, 2=blink all, 3=blink all except selected
digit  in  SEL_W  cursor position
on_time  in  CNT_W  ticks spent in ON phase (0 treated as 1)
off_time  in  CNT_W  ticks spent in OFF phase (0 treated as 1)
digits  in  N_DIGITS  unmasked digit lines
digits_out  out  N_DIGITS  masked digit lines, registered
blink_on  out  1  current phase (1=ON), registered

Behaviour:
- Reset: state=ON, cnt=0, digit_q=0, digits_out=0, blink_on=1.
- States are ON and OFF, and the phase counter is cnt[CNT_W-1:0].
  - On a cycle with tick=1 in ON: if cnt+1 >= max(on_time,1), go to OFF with cnt=0; else cnt+1.
  - OFF is symmetric, using off_time and returning to ON.
  - With tick=0, state and cnt hold.
- Cursor restart: digit_q registers digit every cycle. If digit != digit_q, next state=ON and cnt=0. This overrides any tick transition in the same cycle, so a moved cursor is visible immediately.
- While prog_running=1: state forced to ON, cnt=0. On deassertion the phase starts at ON with a full on_time.
- Duration changes take effect at the next comparison. If cnt already >= the new duration, transition on the next tick.
- Mask per bit i, where sel_i = (digit == i):
  - mode 0: show all.
  - mode 1: show_i = !sel_i | blink_on_n.
  - mode 2: show_i = blink_on_n.
  - mode 3: show_i = sel_i | blink_on_n.
  - prog_running=1 makes show_i=1 for all i regardless of mode.
- blink_on_n is the next-state phase.
- Output: digits_out <= digits & show; blink_on <= (next state == ON). Latency from digits/mode/digit to digits_out is 1 cycle.
- An out-of-range digit (>= N_DIGITS) selects no line: mode 1 behaves as pass-through, mode 3 as blink all.
- Reset asserted mid-phase returns everything to reset values on the next edge. Reset wins over tick and cursor restart.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package ui_pkg holds:
  - mode encoding constants UI_MODE_PASS=0, UI_MODE_SEL=1, UI_MODE_ALL=2, UI_MODE_INV=3;
  - the phase enum (PH_ON, PH_OFF).
- One sub-module, ui_blink_timer, holds the ON/OFF FSM, the counter, and the restart/force logic. Its outputs are phase and next-phase.
- The top level contains the mask generator and the output register.

Test Plan:
- Reset, then digits=32'hFFFFFFFF, mode=1, digit=3, on_time=2, off_time=3, tick every cycle -> 1 cycle after reset, digits_out=FFFFFFFF for 2 ticks, then FFFFFFF7 for 3 ticks, period 5, repeating; blink_on tracks phase.
- In OFF phase, change digit 3->7 -> next cycle blink_on=1 and digits_out=FFFFFFFF. OFF starts exactly on_time ticks later with bit 7 cleared.
- prog_running=1 during OFF, mode=2 -> digits_out equals digits each cycle. Deassert -> ON held for full on_time before first blank.
- mode=3, digit=0, OFF phase, digits=32'hA5A5A5A5 -> digits_out=32'h00000001; mode=0 -> A5A5A5A5 regardless of phase.
- on_time=0, off_time=0, tick every cycle -> phase toggles every tick. tick=0 for 10 cycles -> outputs frozen.
- N_DIGITS=10, SEL_W=4, digit=12, mode=1 -> no bit ever blanked. Assert reset in OFF mid-count -> next cycle digits_out=0, blink_on=1, and the count restarts from 0.
